// File: rtl/irq_latch_ctrl.sv
// Rising-edge event latches sharing one active-low CPU interrupt, fixed priority (index 0 highest).
// Latency: event -> pending 1 edge, pending -> n_irq low 1 more edge; a held ack stalls re-assertion.
module irq_latch_ctrl #(
    parameter int N_SRC   = 4,
    parameter int HOLDOFF = 2,
    parameter int VEC_W   = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N_SRC-1:0] src_trig,
    input  logic [N_SRC-1:0] src_en,
    input  logic             ack,
    output logic             n_irq,
    output logic [VEC_W-1:0] irq_vec,
    output logic [N_SRC-1:0] pending
);

    // Bit 0 of the encoding is the n_irq level, so the output is a flop with no decode.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b01,
        S_ASSERT = 2'b00,
        S_HOLD   = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_SRC-1:0] trig_prev;
    logic [N_SRC-1:0] events;
    logic [N_SRC-1:0] ack_clr;
    logic [3:0]       cnt;
    logic [VEC_W-1:0] first_idx;
    logic             pend_any;
    logic             cur_pend;

    assign events   = src_trig & ~trig_prev & src_en;
    assign pend_any = |pending;
    assign cur_pend = pending[irq_vec];

    always_comb begin
        first_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) first_idx = VEC_W'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        if (state == S_ASSERT && ack) ack_clr[irq_vec] = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pend_any) state_nxt = S_ASSERT;
            S_ASSERT: begin
                if (ack)            state_nxt = S_HOLD;
                else if (!cur_pend) state_nxt = S_IDLE;
            end
            S_HOLD:   if (cnt == 4'd0 && !ack) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        n_irq = state[0];
    end

    // Set wins over a same-edge ack-clear; a disabled source is forced clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            trig_prev <= '1;
            pending   <= '0;
            cnt       <= 4'd0;
            irq_vec   <= '0;
        end else begin
            trig_prev <= src_trig;
            pending   <= (events | (pending & ~ack_clr)) & src_en;
            if (state == S_IDLE && pend_any) irq_vec <= first_idx;
            if (state == S_ASSERT && ack)
                cnt <= 4'(HOLDOFF);
            else if (state == S_HOLD && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_irq_latch_ctrl.sv
// Scoreboarded bench for irq_latch_ctrl: directed scenarios followed by random traffic.
module tb_irq_latch_ctrl;

    localparam int N_SRC   = 4;
    localparam int HOLDOFF = 2;
    localparam int VEC_W   = 2;

    logic             clk;
    logic             n_rst;
    logic [N_SRC-1:0] src_trig;
    logic [N_SRC-1:0] src_en;
    logic             ack;
    logic             n_irq;
    logic [VEC_W-1:0] irq_vec;
    logic [N_SRC-1:0] pending;

    irq_latch_ctrl #(.N_SRC(N_SRC), .HOLDOFF(HOLDOFF), .VEC_W(VEC_W)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .src_trig (src_trig),
        .src_en   (src_en),
        .ack      (ack),
        .n_irq    (n_irq),
        .irq_vec  (irq_vec),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             n_irq;
        logic [VEC_W-1:0] vec;
        logic [N_SRC-1:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    // Reference model: who is being presented, how many quiet cycles remain, which flags are up.
    bit [N_SRC-1:0] m_pend;
    bit [N_SRC-1:0] m_prev;
    bit             m_pres;
    bit             m_hold;
    int             m_wait;
    int             m_vec;

    task automatic m_reset();
        m_pend = '0;
        m_prev = '1;
        m_pres = 1'b0;
        m_hold = 1'b0;
        m_wait = 0;
        m_vec  = 0;
    endtask

    task automatic m_step(input bit [N_SRC-1:0] t, input bit [N_SRC-1:0] e, input bit a);
        bit [N_SRC-1:0] ev;
        bit [N_SRC-1:0] nxt;
        int             lo;
        ev     = t & ~m_prev & e;
        m_prev = t;
        nxt    = m_pend;
        for (int i = 0; i < N_SRC; i++) begin
            if (!e[i])                           nxt[i] = 1'b0;
            else if (ev[i])                      nxt[i] = 1'b1;
            else if (m_pres && a && m_vec == i)  nxt[i] = 1'b0;
        end
        if (m_pres) begin
            if (a) begin
                m_pres = 1'b0;
                m_hold = 1'b1;
                m_wait = HOLDOFF;
            end else if (!m_pend[m_vec]) begin
                m_pres = 1'b0;
            end
        end else if (m_hold) begin
            if (m_wait > 0) m_wait = m_wait - 1;
            else if (!a)    m_hold = 1'b0;
        end else if (m_pend != '0) begin
            lo = 0;
            for (int i = N_SRC - 1; i >= 0; i--) if (m_pend[i]) lo = i;
            m_vec  = lo;
            m_pres = 1'b1;
        end
        m_pend = nxt;
    endtask

    function automatic exp_t m_snapshot();
        exp_t x;
        x.n_irq = ~m_pres;
        x.vec   = VEC_W'(m_vec);
        x.pend  = m_pend;
        return x;
    endfunction

    task automatic step(input bit [N_SRC-1:0] t, input bit [N_SRC-1:0] e, input bit a);
        src_trig = t;
        src_en   = e;
        ack      = a;
        @(posedge clk);
        m_step(t, e, a);
        exp_q.push_back(m_snapshot());
        #1;
    endtask

    task automatic wait_present(input bit [N_SRC-1:0] t);
        for (int i = 0; i < 20; i++) begin
            if (m_pres) return;
            step(t, 4'hF, 1'b0);
        end
        miscompares++;
        $display("FAIL wait_present: no request within 20 cycles, got n_irq=%b want 0", n_irq);
    endtask

    task automatic reset_dut(input bit [N_SRC-1:0] t);
        @(negedge clk);
        #2;
        src_trig = t;
        src_en   = 4'hF;
        ack      = 1'b0;
        n_rst    = 1'b0;
        #1;
        vectors++;
        if (n_irq !== 1'b1 || irq_vec !== '0 || pending !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got n_irq=%b vec=%0d pend=%b want 1/0/0000",
                     n_irq, irq_vec, pending);
        end
        m_reset();
        exp_q.push_back(m_snapshot());
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            vectors++;
            if (n_irq !== x.n_irq || irq_vec !== x.vec || pending !== x.pend) begin
                miscompares++;
                $display("FAIL snapshot%0d @%0t: n_irq/vec/pend got %b/%0d/%b want %b/%0d/%b",
                         vectors, $time, n_irq, irq_vec, pending, x.n_irq, x.vec, x.pend);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_rst       = 1'b0;
        src_trig    = 4'b0011;
        src_en      = 4'hF;
        ack         = 1'b0;
        m_reset();

        // Sources already high at reset release are not events.
        reset_dut(4'b0011);
        repeat (10) step(4'b0011, 4'hF, 1'b0);

        // Single event, presented then acknowledged.
        step(4'b0000, 4'hF, 1'b0);
        step(4'b0100, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b0);
        wait_present(4'b0000);
        repeat (2) step(4'b0000, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b1);
        repeat (5) step(4'b0000, 4'hF, 1'b0);

        // Simultaneous sources 3 and 1: 1 first, then 3 after holdoff.
        step(4'b1010, 4'hF, 1'b0);
        wait_present(4'b1010);
        step(4'b1010, 4'hF, 1'b1);
        wait_present(4'b0000);
        step(4'b0000, 4'hF, 1'b1);
        repeat (5) step(4'b0000, 4'hF, 1'b0);

        // Retrigger of source 0 on its own ack edge.
        step(4'b0001, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b0);
        wait_present(4'b0000);
        step(4'b0001, 4'hF, 1'b1);
        repeat (6) step(4'b0000, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b1);
        repeat (4) step(4'b0000, 4'hF, 1'b0);

        // Masking the presented source withdraws the request without holdoff.
        step(4'b0100, 4'hF, 1'b0);
        wait_present(4'b0000);
        repeat (3) step(4'b0000, 4'b1011, 1'b0);
        step(4'b0000, 4'hF, 1'b0);

        // Held ack stalls re-assertion of another pending source.
        step(4'b0110, 4'hF, 1'b0);
        wait_present(4'b0000);
        repeat (7) step(4'b0000, 4'hF, 1'b1);
        repeat (5) step(4'b0000, 4'hF, 1'b0);
        step(4'b0000, 4'hF, 1'b1);
        repeat (4) step(4'b0000, 4'hF, 1'b0);

        // Reset in the middle of a request drops everything.
        step(4'b1000, 4'hF, 1'b0);
        step(4'b0001, 4'hF, 1'b0);
        wait_present(4'b0000);
        reset_dut(4'b0000);
        repeat (3) step(4'b0000, 4'hF, 1'b0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit [N_SRC-1:0] t;
            bit [N_SRC-1:0] e;
            bit             a;
            t = N_SRC'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) t = t & N_SRC'($urandom_range(0, 15));
            e = ($urandom_range(0, 7) == 0) ? N_SRC'($urandom_range(0, 15)) : 4'hF;
            a = ($urandom_range(0, 2) == 0);
            step(t, e, a);
            if (n == 1500) reset_dut(4'b0101);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
